// File: rtl/exec_wb_seq_if.sv
// rtl/exec_wb_seq_if.sv - instruction handshake and register-file port bundle for exec_wb_seq
interface exec_wb_seq_if;
   logic        in_valid;
   logic [31:0] in_instr;
   logic        in_ready;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] rv1;
   logic [31:0] rv2;
   logic        we;
   logic [4:0]  rd;
   logic [31:0] indata;
   logic        done;
   logic        err;
   logic [31:0] retire_cnt;

   modport slave (
      input  in_valid, in_instr, rv1, rv2,
      output in_ready, rs1, rs2, we, rd, indata, done, err, retire_cnt
   );

   modport master (
      output in_valid, in_instr, rv1, rv2,
      input  in_ready, rs1, rs2, we, rd, indata, done, err, retire_cnt
   );
endinterface

// File: rtl/exec_wb_seq.sv
// rtl/exec_wb_seq.sv - RV32I OP/OP-IMM execute/write-back sequencer; barrel shifter under `EXEC_SHIFT_EN
module exec_wb_seq (
   input  logic         clk,
   input  logic         rst,
   exec_wb_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

   state_t      state_q, state_d;
   // Only the fields needed after accept: {imm[11:0], funct3, rd, opcode}
   logic [26:0] instr_q;
   logic [4:0]  rs1_q, rs2_q, rd_q;
   logic [31:0] result_q, cnt_q;

   logic [6:0]  opcode, f7;
   logic [2:0]  f3;
   logic        is_op, is_imm, legal;
   logic [31:0] opb, result;
   logic        in_ready_c, we_c, done_c, err_c;

   assign opcode = instr_q[6:0];
   assign f3     = instr_q[14:12];
   assign f7     = instr_q[26:20];
   assign is_op  = (opcode == 7'b0110011);
   assign is_imm = (opcode == 7'b0010011);
   assign opb    = is_op ? bus.rv2 : {{20{instr_q[26]}}, instr_q[26:15]};

`ifdef EXEC_SHIFT_EN
   logic [4:0] shamt;
   assign shamt = opb[4:0];
`endif

   always_comb begin
      legal  = 1'b0;
      result = '0;
      if (is_op || is_imm) begin
         case (f3)
            3'b000: begin
               // OP-IMM carries immediate bits in f7, so SUB is OP-only
               legal  = is_imm || (f7 == 7'b0000000) || (f7 == 7'b0100000);
               result = (is_op && f7[5]) ? bus.rv1 - opb : bus.rv1 + opb;
            end
            3'b010: begin
               legal  = is_imm || (f7 == 7'b0000000);
               result = {31'b0, $signed(bus.rv1) < $signed(opb)};
            end
            3'b011: begin
               legal  = is_imm || (f7 == 7'b0000000);
               result = {31'b0, bus.rv1 < opb};
            end
            3'b100: begin
               legal  = is_imm || (f7 == 7'b0000000);
               result = bus.rv1 ^ opb;
            end
            3'b110: begin
               legal  = is_imm || (f7 == 7'b0000000);
               result = bus.rv1 | opb;
            end
            3'b111: begin
               legal  = is_imm || (f7 == 7'b0000000);
               result = bus.rv1 & opb;
            end
`ifdef EXEC_SHIFT_EN
            3'b001: begin
               legal  = (f7 == 7'b0000000);
               result = bus.rv1 << shamt;
            end
            3'b101: begin
               legal  = (f7 == 7'b0000000) || (f7 == 7'b0100000);
               result = f7[5] ? 32'($signed(bus.rv1) >>> shamt) : bus.rv1 >> shamt;
            end
`endif
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      state_d    = state_q;
      in_ready_c = 1'b0;
      we_c       = 1'b0;
      done_c     = 1'b0;
      err_c      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) state_d = READ;
         end
         READ: state_d = EXEC;
         EXEC: begin
            err_c   = !legal;
            state_d = legal ? WB : IDLE;
         end
         WB: begin
            we_c    = (rd_q != 5'd0);
            done_c  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Reset aborts the instruction in flight, including a pending write-back
      if (rst) begin
         in_ready_c = 1'b0;
         we_c       = 1'b0;
         done_c     = 1'b0;
         err_c      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q  <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         rd_q     <= '0;
         result_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (state_q == IDLE && bus.in_valid) begin
            instr_q <= {bus.in_instr[31:20], bus.in_instr[14:12], bus.in_instr[11:7], bus.in_instr[6:0]};
            rs1_q   <= bus.in_instr[19:15];
            rs2_q   <= bus.in_instr[24:20];
         end
         if (state_q == EXEC && legal) begin
            result_q <= result;
            rd_q     <= instr_q[11:7];
         end
         if (done_c) cnt_q <= cnt_q + 32'd1;
      end
   end

   assign bus.in_ready   = in_ready_c;
   assign bus.rs1        = rs1_q;
   assign bus.rs2        = rs2_q;
   assign bus.we         = we_c;
   assign bus.rd         = rd_q;
   assign bus.indata     = result_q;
   assign bus.done       = done_c;
   assign bus.err        = err_c;
   assign bus.retire_cnt = cnt_q;
endmodule

// File: tb/tb_exec_wb_seq.sv
// tb/tb_exec_wb_seq.sv - randomized bench for exec_wb_seq against an instruction-level reference model
module tb_exec_wb_seq;
   logic clk = 1'b0;
   logic rst;
   logic [31:0] regs [32];
   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] model_cnt = 0;

   exec_wb_seq_if bus ();
   exec_wb_seq dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   assign bus.rv1 = regs[bus.rs1];
   assign bus.rv2 = regs[bus.rs2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Architectural result of one instruction, written from the ISA rules
   function automatic void ref_exec(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] r2,
                                    output bit ok, output logic [31:0] res);
      logic [6:0]  opc = ins[6:0];
      logic [2:0]  f3  = ins[14:12];
      logic [6:0]  f7  = ins[31:25];
      bit          op  = (opc == 7'h33);
      bit          imm = (opc == 7'h13);
      logic [31:0] b;
      logic [63:0] pw;
      ok  = 1'b0;
      res = '0;
      if (!op && !imm) return;
      b  = op ? r2 : 32'($signed(ins) >>> 20);
      pw = 64'd1 << (b % 32);
      case (f3)
         3'd0: begin ok = imm || f7 == 7'h00 || f7 == 7'h20; res = (op && f7 == 7'h20) ? a - b : a + b; end
         3'd2: begin ok = imm || f7 == 7'h00; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
         3'd3: begin ok = imm || f7 == 7'h00; res = (a < b) ? 32'd1 : 32'd0; end
         3'd4: begin ok = imm || f7 == 7'h00; res = a ^ b; end
         3'd6: begin ok = imm || f7 == 7'h00; res = a | b; end
         3'd7: begin ok = imm || f7 == 7'h00; res = a & b; end
`ifdef EXEC_SHIFT_EN
         3'd1: begin ok = (f7 == 7'h00); res = 32'(64'(a) * pw); end
         3'd5: begin
            ok = (f7 == 7'h00) || (f7 == 7'h20);
            if (f7 == 7'h20 && a[31]) res = ~32'(64'(~a) / pw);
            else                      res = 32'(64'(a) / pw);
         end
`endif
         default: ok = 1'b0;
      endcase
   endfunction

   task automatic wait_idle();
      int k;
      for (k = 0; k < 16 && bus.in_ready !== 1'b1; k++) @(negedge clk);
      if (bus.in_ready !== 1'b1) check("idle_timeout", {31'b0, bus.in_ready}, 32'd1);
   endtask

   task automatic randomize_regs();
      regs[0] = '0;
      for (int i = 1; i < 32; i++) regs[i] = $urandom;
   endtask

   // Issues one instruction at a negedge and checks it cycle by cycle
   task automatic run_instr(input logic [31:0] ins);
      bit ok;
      logic [31:0] exp;
      wait_idle();
      bus.in_valid = 1'b1;
      bus.in_instr = ins;
      @(negedge clk);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_instr = $urandom;
      ref_exec(ins, regs[ins[19:15]], regs[ins[24:20]], ok, exp);
      check("rs1", {27'b0, bus.rs1}, {27'b0, ins[19:15]});
      check("rs2", {27'b0, bus.rs2}, {27'b0, ins[24:20]});
      check("busy_ready", {31'b0, bus.in_ready}, 32'd0);
      @(negedge clk);
      check("exec_err", {31'b0, bus.err}, {31'b0, !ok});
      check("exec_we", {31'b0, bus.we}, 32'd0);
      @(negedge clk);
      if (ok) begin
         model_cnt = model_cnt + 1;
         check("wb_we", {31'b0, bus.we}, {31'b0, ins[11:7] != 5'd0});
         check("wb_done", {31'b0, bus.done}, 32'd1);
         check("wb_err", {31'b0, bus.err}, 32'd0);
         check("wb_rd", {27'b0, bus.rd}, {27'b0, ins[11:7]});
         check("wb_indata", bus.indata, exp);
         bus.in_valid = 1'b0;
         @(negedge clk);
         check("post_ready", {31'b0, bus.in_ready}, 32'd1);
         check("post_done", {31'b0, bus.done}, 32'd0);
         check("hold_indata", bus.indata, exp);
      end else begin
         check("ill_ready", {31'b0, bus.in_ready}, 32'd1);
         check("ill_done", {31'b0, bus.done | bus.we}, 32'd0);
         bus.in_valid = 1'b0;
      end
      check("retire_cnt", bus.retire_cnt, model_cnt);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w = $urandom;
      int k = $urandom_range(0, 9);
      int f = $urandom_range(0, 4);
      if (k < 4)      w[6:0] = 7'h33;
      else if (k < 8) w[6:0] = 7'h13;
      if (f < 3)       w[31:25] = 7'h00;
      else if (f == 3) w[31:25] = 7'h20;
      return w;
   endfunction

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int acc, dn;
      randomize_regs();
      rst = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h00528293;
      @(negedge clk);
      @(negedge clk);
      check("rst_ready", {31'b0, bus.in_ready}, 32'd0);
      check("rst_rs1", {27'b0, bus.rs1}, 32'd0);
      check("rst_outs", {29'b0, bus.we, bus.done, bus.err}, 32'd0);
      check("rst_indata", bus.indata, 32'd0);
      check("rst_cnt", bus.retire_cnt, 32'd0);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("rel_ready", {31'b0, bus.in_ready}, 32'd1);

      run_instr(32'h00500093);
      check("addi_val", bus.indata, 32'h00000005);
      regs[1] = 32'd3;
      regs[2] = 32'd5;
      run_instr(32'h402081B3);
      check("sub_val", bus.indata, 32'hFFFFFFFE);
      run_instr(32'h0020B1B3);
      check("sltu_val", bus.indata, 32'd1);
      regs[1] = 32'h80000000;
      run_instr(32'h4040D213);
`ifdef EXEC_SHIFT_EN
      check("srai_val", bus.indata, 32'hF8000000);
`endif
      run_instr(32'h00208033);
      run_instr(32'h0000006F);

      for (int i = 0; i < 40; i++) begin
         randomize_regs();
         run_instr(rand_instr());
      end

      // Reset while an instruction is in EXEC
      wait_idle();
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h002082B3;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_we_done", {30'b0, bus.we, bus.done}, 32'd0);
      check("abort_ready", {31'b0, bus.in_ready}, 32'd0);
      check("abort_regs", {17'b0, bus.rs1, bus.rs2, bus.rd}, 32'd0);
      check("abort_indata", bus.indata, 32'd0);
      check("abort_cnt", bus.retire_cnt, 32'd0);
      model_cnt = 0;
      rst = 1'b0;
      @(negedge clk);
      check("abort_rel_ready", {31'b0, bus.in_ready}, 32'd1);
      check("abort_rel_done", {30'b0, bus.we, bus.done}, 32'd0);

      // in_valid held high: one accept every fourth cycle
      regs[0] = '0;
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h00500093;
      acc = 0;
      dn = 0;
      for (int c = 0; c < 12; c++) begin
         acc += int'(bus.in_ready);
         dn  += int'(bus.done);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      model_cnt = model_cnt + 3;
      check("hold_accepts", 32'(acc), 32'd3);
      check("hold_dones", 32'(dn), 32'd3);
      check("hold_cnt", bus.retire_cnt, model_cnt);

      // Counter wrap
      wait_idle();
      force dut.cnt_q = 32'hFFFFFFFF;
      @(negedge clk);
      release dut.cnt_q;
      model_cnt = 32'hFFFFFFFF;
      run_instr(32'h00500093);
      check("cnt_wrap", bus.retire_cnt, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/exec_wb_seq.md
# exec_wb_seq

Multicycle execute/write-back sequencer that sits directly upstream of the 32x32 register file (`reg_file`). Accepts one RV32I integer ALU instruction (OP / OP-IMM) at a time, drives the register file read addresses, computes the result from `rv1`/`rv2` and writes it back through the file's `we`/`rd`/`indata` port. Gives the board a self-contained datapath slice that VIO can drive and ILA can observe.

## Interface
Parameters:
- none; all widths are fixed (32-bit data, 5-bit register addresses).

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  instruction present on `in_instr`
- `in_instr`  in  32  RV32I instruction word
- `in_ready`  out  1  sequencer idle; instruction accepted when `in_valid & in_ready`
- `rs1`  out  5  register file read address 1 (registered)
- `rs2`  out  5  register file read address 2 (registered)
- `rv1`  in  32  register file read data 1
- `rv2`  in  32  register file read data 2
- `we`  out  1  register file write enable (one-cycle pulse)
- `rd`  out  5  register file write address
- `indata`  out  32  register file write data
- `done`  out  1  one-cycle pulse: instruction retired (legal)
- `err`  out  1  one-cycle pulse: instruction rejected (illegal)
- `retire_cnt`  out  32  count of retired legal instructions

## Operation
- FSM states: IDLE, READ, EXEC, WB.
- IDLE: `in_ready`=1. On `in_valid`: latch `in_instr`, load `rs1`=instr[19:15], `rs2`=instr[24:20] → READ. Otherwise stay.
- READ: wait one cycle for register file read data to settle → EXEC.
- EXEC: decode; if legal, compute result from `rv1` and operand B into a result register, load `rd`=instr[11:7] → WB. If illegal: pulse `err`, no write → IDLE.
- WB: `we`=1 unless `rd`=0 (x0 write suppressed, `we` stays 0); `indata`=result; pulse `done`; increment `retire_cnt` → IDLE.
- Legal opcodes: 0110011 (OP), 0010011 (OP-IMM); anything else is illegal.
- Operand B: OP uses `rv2`; OP-IMM uses instr[31:20] sign-extended to 32 bits.
- funct3: 000 ADD/SUB (SUB only OP with funct7=0100000; OP-IMM has no SUB), 001 SLL, 010 SLT (signed), 011 SLTU, 100 XOR, 101 SRL/SRA (funct7[5] selects SRA), 110 OR, 111 AND.
- OP funct7 must be 0000000, or 0100000 only for funct3 000/101; otherwise illegal. SLLI needs instr[31:25]=0; SRLI/SRAI need instr[31:25] ∈ {0000000, 0100000}.
- Shift amount: operand B[4:0]. SLT/SLTU result is 0 or 1 zero-extended. Add/sub wrap modulo 2^32, no overflow flag.
- `retire_cnt` increments on every `done` (including x0 writes); wraps 0xFFFFFFFF → 0.
- `in_valid` outside IDLE is ignored; the upstream source must hold the instruction until accepted.

## Timing
- Accept at edge N (IDLE, `in_valid`=1): `rs1`/`rs2` valid after N; `we`/`done` high for cycle N+3 exactly; IDLE again at N+4; `in_ready` high from N+4. Throughput one instruction per 4 cycles.
- Illegal: `err` high for cycle N+2; IDLE at N+3.
- `we`, `done`, `err` are never high for more than one cycle and never together with each other except `we`+`done`.
- `rd`, `indata` hold their last values outside WB; only `we` qualifies them.
- Reset values (cycle after `rst` sampled high): state IDLE, `rs1`=`rs2`=`rd`=0, `indata`=0, `we`=`done`=`err`=0, `retire_cnt`=0, `in_ready`=0 while `rst` is high, 1 once released.
- Reset in any state aborts the instruction: no `we`, no `done`, counter cleared. Reset dominates a simultaneous accept.

## Configuration
- `EXEC_SHIFT_EN` defined: SLL/SRL/SRA/SLLI/SRLI/SRAI execute as above (barrel shifter compiled in).
- Not defined: no shifter; funct3 001 and 101 are treated as illegal (`err` pulse, no write). All other behaviour unchanged.

## Test plan
- ADDI x1,x0,5 (0x00500093), `rv1`=0 → `we`=1, `rd`=1, `indata`=0x00000005 at N+3; `done` pulse; `retire_cnt`=1.
- SUB x3,x1,x2 (0x402081B3), `rv1`=3, `rv2`=5 → `indata`=0xFFFFFFFE, `rd`=3; SLTU same operands → `indata`=1.
- SRAI x4,x1,4 (0x4040D213), `rv1`=0x80000000 → with `EXEC_SHIFT_EN` `indata`=0xF8000000; without it `err` at N+2, `we` never asserted.
- ADD x0,x1,x2 (0x00208033) → `we` stays 0, `done` pulses, `retire_cnt` increments; JAL (0x0000006F) → `err` at N+2, no `we`, counter unchanged.
- `rst` asserted during EXEC → no `we`/`done` follows, all outputs at reset values, `in_ready`=1 the cycle after release; `in_valid` held high during READ/EXEC/WB of another instruction → exactly one accept per 4 cycles.
- Preload `retire_cnt` by 2^32−1 retirements (or forced value 0xFFFFFFFF) then one ADDI → `retire_cnt`=0.
